// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: arbiter state encoding, arbitration timing default
// and the bus-busy tracking rule used by the nubus_slave-family blocks.
package nubus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FAIRWAIT = 3'd1,
    ST_ARB      = 3'd2,
    ST_WAITBUS  = 3'd3,
    ST_OWNER    = 3'd4
  } nub_state_e;

  localparam int ARB_CYCLES_DEF = 2;

  // START opens a transaction, ACK closes it; START with ACK is an attention cycle.
  function automatic logic busy_next(input logic busy, input logic start, input logic ack);
    logic nxt;
    if (start && !ack) begin
      nxt = 1'b1;
    end else if (ack && !start) begin
      nxt = 1'b0;
    end else begin
      nxt = busy;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nubus_arb_resolve.sv
// Combinational /ARB bit resolution: each ID bit keeps driving only while no
// more significant bit shows a competitor that this slot is not driving itself.
module nubus_arb_resolve (
  input  logic [3:0] id_i,
  input  logic [3:0] arb_i,
  output logic [3:0] arb_oe_o,
  output logic       win_o
);

  logic lose_s;

  // Scan from the MSB, accumulating "a higher competitor bit is present".
  always_comb begin
    arb_oe_o = 4'h0;
    lose_s   = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      arb_oe_o[k] = id_i[k] & ~lose_s;
      lose_s      = lose_s | (arb_i[k] & ~id_i[k]);
    end
  end

  assign win_o = (arb_i == id_i);

endmodule

// File: rtl/nubus_arbiter.sv
// NuBus distributed arbiter for one slot: fair /RQST entry, timed /ARB contest,
// wait for the bus to go idle, then hold tenure (optionally locked) until ACK.
module nubus_arbiter
  import nubus_pkg::*;
#(
  parameter int ARB_CYCLES = ARB_CYCLES_DEF
) (
  input  logic       nub_clkn,
  input  logic       nub_reset,
  input  logic [3:0] nub_idn,
  input  logic       mst_req,
  input  logic       mst_lock,
  input  logic       mst_start,
  input  logic       nub_rqstn,
  input  logic [3:0] nub_arbn,
  input  logic       nub_startn,
  input  logic       nub_ackn,
  output logic       rqst_oe,
  output logic [3:0] arb_oe,
  output logic       grant_o,
  output logic       bus_busy_o
);

  localparam logic [7:0] CNT_LAST = 8'(ARB_CYCLES - 1);

  logic [3:0] id_s;
  logic [3:0] arb_s;
  logic       rqst_s;
  logic       start_s;
  logic       ack_s;

  assign id_s    = ~nub_idn;
  assign arb_s   = ~nub_arbn;
  assign rqst_s  = ~nub_rqstn;
  assign start_s = ~nub_startn;
  assign ack_s   = ~nub_ackn;

  logic [3:0] res_oe_s;
  logic       win_s;

  nubus_arb_resolve u_resolve (
    .id_i     (id_s),
    .arb_i    (arb_s),
    .arb_oe_o (res_oe_s),
    .win_o    (win_s)
  );

  nub_state_e state_q;
  logic [7:0] cnt_q;
  logic       lost_q;
  logic       saw_drop_q;
  logic       started_q;
  logic       ready_q;
  logic       rqst_oe_q;
  logic       arb_en_q;
  logic       grant_q;
  logic       bus_busy_q;
  logic       bus_busy_d;

  assign bus_busy_d = busy_next(bus_busy_q, start_s, ack_s);

  // Track whether any master's transaction is in flight on the bus.
  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      bus_busy_q <= 1'b0;
    end else begin
      bus_busy_q <= bus_busy_d;
    end
  end

  // Tenure state machine with registered /RQST, /ARB-enable and grant.
  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      lost_q     <= 1'b0;
      saw_drop_q <= 1'b0;
      started_q  <= 1'b0;
      ready_q    <= 1'b0;
      rqst_oe_q  <= 1'b0;
      arb_en_q   <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          // ready_q keeps at least one clock in IDLE after reset release.
          if (mst_req && ready_q && rqst_s) begin
            state_q <= ST_FAIRWAIT;
          end else if (mst_req && ready_q) begin
            state_q    <= ST_ARB;
            rqst_oe_q  <= 1'b1;
            arb_en_q   <= 1'b1;
            cnt_q      <= 8'd0;
            lost_q     <= 1'b0;
            saw_drop_q <= 1'b0;
          end
        end
        ST_FAIRWAIT: begin
          if (!mst_req) begin
            state_q <= ST_IDLE;
          end else if (!rqst_s) begin
            state_q    <= ST_ARB;
            rqst_oe_q  <= 1'b1;
            arb_en_q   <= 1'b1;
            cnt_q      <= 8'd0;
            lost_q     <= 1'b0;
            saw_drop_q <= 1'b0;
          end
        end
        ST_ARB: begin
          if (!mst_req) begin
            state_q    <= ST_IDLE;
            rqst_oe_q  <= 1'b0;
            arb_en_q   <= 1'b0;
            lost_q     <= 1'b0;
            saw_drop_q <= 1'b0;
          end else if (lost_q) begin
            // A lost contest restarts only after /RQST drops and rises again.
            if (!rqst_s) begin
              saw_drop_q <= 1'b1;
            end else if (saw_drop_q) begin
              lost_q     <= 1'b0;
              saw_drop_q <= 1'b0;
              cnt_q      <= 8'd0;
            end
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else if (win_s) begin
            state_q <= ST_WAITBUS;
          end else begin
            lost_q <= 1'b1;
          end
        end
        ST_WAITBUS: begin
          if (!mst_req) begin
            state_q   <= ST_IDLE;
            rqst_oe_q <= 1'b0;
            arb_en_q  <= 1'b0;
          end else if (ack_s || (!bus_busy_q && !start_s)) begin
            state_q   <= ST_OWNER;
            arb_en_q  <= 1'b0;
            grant_q   <= 1'b1;
            started_q <= 1'b0;
          end
        end
        ST_OWNER: begin
          if (mst_start) begin
            started_q <= 1'b1;
          end
          if (mst_start && !mst_lock) begin
            rqst_oe_q <= 1'b0;
          end
          if (ack_s && started_q && !mst_lock) begin
            state_q   <= mst_req ? ST_FAIRWAIT : ST_IDLE;
            grant_q   <= 1'b0;
            rqst_oe_q <= 1'b0;
            started_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= 8'd0;
          lost_q     <= 1'b0;
          saw_drop_q <= 1'b0;
          started_q  <= 1'b0;
          rqst_oe_q  <= 1'b0;
          arb_en_q   <= 1'b0;
          grant_q    <= 1'b0;
        end
      endcase
    end
  end

  // /ARB follows the live resolver, but only while contesting or awaiting the bus.
  always_comb begin
    arb_oe = 4'h0;
    if (arb_en_q) begin
      arb_oe = res_oe_s;
    end else begin
      arb_oe = 4'h0;
    end
  end

  assign rqst_oe    = rqst_oe_q;
  assign grant_o    = grant_q;
  assign bus_busy_o = bus_busy_q;

endmodule

// File: tb/tb_nubus_arbiter.sv
// Scoreboard bench for nubus_arbiter: each row drives one clock of stimulus and
// queues the outputs expected after that edge; /ARB is modelled as a wired-OR.
module tb_nubus_arbiter;

  logic       nub_clkn = 1'b0;
  logic       nub_reset;
  logic [3:0] nub_idn;
  logic       mst_req;
  logic       mst_lock;
  logic       mst_start;
  logic       nub_rqstn;
  logic [3:0] nub_arbn;
  logic       nub_startn;
  logic       nub_ackn;
  logic       rqst_oe;
  logic [3:0] arb_oe;
  logic       grant_o;
  logic       bus_busy_o;

  logic [3:0] ext_arb;
  logic [6:0] obs_s;
  int         checks   = 0;
  int         failures = 0;
  logic [6:0] sb_q[$];

  // ctl = {mst_req, mst_lock, mst_start, ext_rqst}; sa = {start, ack};
  // want = {rqst_oe, arb_oe[3:0], grant_o, bus_busy_o}
  typedef struct packed {
    logic [3:0] ctl;
    logic [3:0] xa;
    logic [1:0] sa;
    logic [6:0] want;
  } row_t;

  assign obs_s = {rqst_oe, arb_oe, grant_o, bus_busy_o};

  nubus_arbiter #(.ARB_CYCLES(2)) dut (
    .nub_clkn   (nub_clkn),
    .nub_reset  (nub_reset),
    .nub_idn    (nub_idn),
    .mst_req    (mst_req),
    .mst_lock   (mst_lock),
    .mst_start  (mst_start),
    .nub_rqstn  (nub_rqstn),
    .nub_arbn   (nub_arbn),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .rqst_oe    (rqst_oe),
    .arb_oe     (arb_oe),
    .grant_o    (grant_o),
    .bus_busy_o (bus_busy_o)
  );

  always #10 nub_clkn = ~nub_clkn;

  function automatic row_t mk(input logic [3:0] ctl, input logic [3:0] xa, input logic [1:0] sa,
                              input logic rq, input logic [3:0] ao, input logic [1:0] gb);
    row_t r;
    r.ctl  = ctl;
    r.xa   = xa;
    r.sa   = sa;
    r.want = {rq, ao, gb};
    return r;
  endfunction

  task automatic settle();
    repeat (4) begin
      nub_arbn = ~(arb_oe | ext_arb);
      #1;
    end
  endtask

  task automatic drive(input row_t rw);
    mst_req    = rw.ctl[3];
    mst_lock   = rw.ctl[2];
    mst_start  = rw.ctl[1];
    nub_rqstn  = ~rw.ctl[0];
    ext_arb    = rw.xa;
    nub_startn = ~rw.sa[1];
    nub_ackn   = ~rw.sa[0];
    sb_q.push_back(rw.want);
    settle();
  endtask

  task automatic tick();
    @(posedge nub_clkn);
    #1;
    settle();
  endtask

  task automatic test_reset();
    row_t       rows[$];
    logic [6:0] e;
    nub_reset  = 1'b1;
    nub_idn    = ~4'hA;
    mst_req    = 1'b0;
    mst_lock   = 1'b0;
    mst_start  = 1'b0;
    nub_rqstn  = 1'b1;
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    ext_arb    = 4'h0;
    nub_arbn   = 4'hF;
    #1;
    checks++;
    if (obs_s !== 7'h00) begin
      failures++;
      $display("FAIL reset_initial: rqst/arb/grant/busy got %b want %b", obs_s, 7'h00);
    end
    repeat (2) @(posedge nub_clkn);
    #3;
    nub_reset = 1'b0;
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      if (i == 6) begin
        nub_reset = 1'b1;
        #1;
        checks++;
        if (obs_s !== 7'h00) begin
          failures++;
          $display("FAIL reset_mid_owner: rqst/arb/grant/busy got %b want %b", obs_s, 7'h00);
        end
        #1;
        nub_reset = 1'b0;
      end
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL reset_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  task automatic test_sole();
    row_t       rows[$];
    logic [6:0] e;
    nub_idn = ~4'hA;
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1010, 4'h0, 2'b10, 1'b0, 4'h0, 2'b11));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b11));
    rows.push_back(mk(4'b0000, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL sole_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  task automatic test_contention();
    row_t       rows[$];
    logic [6:0] e;
    nub_idn = ~4'h5;
    rows.push_back(mk(4'b1000, 4'h2, 2'b00, 1'b1, 4'h4, 2'b00));
    rows.push_back(mk(4'b1001, 4'hC, 2'b00, 1'b1, 4'h0, 2'b00));
    rows.push_back(mk(4'b1001, 4'hC, 2'b00, 1'b1, 4'h0, 2'b00));
    rows.push_back(mk(4'b1001, 4'hC, 2'b00, 1'b1, 4'h0, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'h5, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b1, 4'h5, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b1, 4'h5, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b1, 4'h5, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b0010, 4'h0, 2'b10, 1'b0, 4'h0, 2'b11));
    rows.push_back(mk(4'b0000, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL contention_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  task automatic test_fairness();
    row_t       rows[$];
    logic [6:0] e;
    nub_idn = ~4'hA;
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL fairness_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  task automatic test_busy_bus();
    row_t       rows[$];
    logic [6:0] e;
    nub_idn = ~4'hA;
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b10, 1'b1, 4'hA, 2'b01));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b01));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b01));
    rows.push_back(mk(4'b1000, 4'h0, 2'b01, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1000, 4'h0, 2'b11, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1010, 4'h0, 2'b10, 1'b0, 4'h0, 2'b11));
    rows.push_back(mk(4'b0000, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL busy_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  task automatic test_lock();
    row_t       rows[$];
    logic [6:0] e;
    nub_idn = ~4'hA;
    rows.push_back(mk(4'b1100, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1100, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1100, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b1100, 4'h0, 2'b00, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1110, 4'h0, 2'b10, 1'b1, 4'h0, 2'b11));
    rows.push_back(mk(4'b1100, 4'h0, 2'b01, 1'b1, 4'h0, 2'b10));
    rows.push_back(mk(4'b1110, 4'h0, 2'b10, 1'b1, 4'h0, 2'b11));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'h0, 2'b11));
    rows.push_back(mk(4'b1000, 4'h0, 2'b01, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1001, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    rows.push_back(mk(4'b1000, 4'h0, 2'b00, 1'b1, 4'hA, 2'b00));
    rows.push_back(mk(4'b0000, 4'h0, 2'b00, 1'b0, 4'h0, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb_q.pop_front();
      checks++;
      if (obs_s !== e) begin
        failures++;
        $display("FAIL lock_row%0d: rqst/arb/grant/busy got %b want %b", i, obs_s, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sole();
    test_contention();
    test_fairness();
    test_busy_bus();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nubus_arbiter.md
NUBUS_ARBITER -- requirements
Module: nubus_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ARB_CYCLES, 2, clocks from RQST assertion to arbitration result.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- nub_clkn, in, 1: bus clock; all state changes on its rising edge.
- nub_reset, in, 1: asynchronous, active-high reset.
- nub_idn, in, 4: slot ID (active low).
- mst_req, in, 1: local master wants a bus tenure.
- mst_lock, in, 1: keep tenure across transactions.
- mst_start, in, 1: local master drives START this cycle.
- nub_rqstn, in, 1: sampled /RQST bus line.
- nub_arbn, in, 4: sampled /ARB bus lines.
- nub_startn, in, 1: sampled /START.
- nub_ackn, in, 1: sampled /ACK.
- rqst_oe, out, 1: drive /RQST low.
- arb_oe, out, 4: per-bit drive of /ARB low.
- grant_o, out, 1: local master owns the bus.
- bus_busy_o, out, 1: a transaction is in flight on the bus.

Function
REQ-003 Active-high internal views SHALL be: id=~nub_idn, arb=~nub_arbn, rqst=~nub_rqstn, start=~nub_startn, ack=~nub_ackn.
REQ-004 bus_busy SHALL be set on start&~ack, cleared on ack&~start, and unchanged on start&ack (attention cycle) or when neither is asserted.
REQ-005 States SHALL be IDLE, FAIRWAIT, ARB, WAITBUS and OWNER.
REQ-006 IDLE SHALL go to ARB when mst_req&~rqst, and to FAIRWAIT when mst_req&rqst.
REQ-007 FAIRWAIT SHALL go to ARB on the first cycle with ~rqst; the fairness rule is that no new request is allowed while another /RQST is pending.
REQ-008 In ARB, WAITBUS and OWNER (until release), rqst_oe SHALL be 1.
REQ-009 In ARB and WAITBUS, arb_oe[k] SHALL be id[k] & ~(OR over j>k of arb[j]&~id[j]); this is combinational from sampled arb.
REQ-010 ARB SHALL last exactly ARB_CYCLES clocks from entry.
REQ-011 At the end of ARB, if arb==id the block SHALL go to WAITBUS; otherwise it SHALL stay in ARB, keep requesting, and restart the count when rqst is seen deasserted then reasserted.
REQ-012 WAITBUS SHALL go to OWNER on the first cycle where bus_busy=0 and start=0 (or ack=1).
REQ-013 grant_o SHALL be 1 exactly in OWNER.
REQ-014 In OWNER with mst_start=1 and mst_lock=0, rqst_oe and arb_oe SHALL deassert on the next clock.
REQ-015 OWNER SHALL return to IDLE on ack following the last mst_start, provided mst_lock=0.
REQ-016 With mst_lock=1, the block SHALL stay in OWNER with rqst_oe=1 through successive transactions, and SHALL exit on the first ack after mst_lock falls.
REQ-017 mst_req falling in FAIRWAIT, ARB or WAITBUS SHALL return the block to IDLE and deassert all drives next clock.
REQ-018 After leaving OWNER, the block SHALL enter FAIRWAIT (not ARB) when mst_req is still 1.
REQ-019 arb_oe SHALL be 0 in IDLE, FAIRWAIT and OWNER.

Reset
REQ-020 nub_reset SHALL asynchronously force IDLE, rqst_oe=0, arb_oe=0, grant_o=0, bus_busy_o=0 and ARB counter=0.
REQ-021 Reset asserted mid-tenure SHALL drop every drive immediately, with no handshake.
REQ-022 After reset release, the block SHALL take at least one clock in IDLE before requesting.

Structure
REQ-023 State encoding and ARB_CYCLES default SHALL live in a shared nubus package used by nubus_slave-family blocks.
REQ-024 The combinational ARB-bit resolution of REQ-009 SHALL be one sub-module, nubus_arb_resolve (inputs id, arb; outputs arb_oe, win).
REQ-025 No other sub-modules SHALL be used.

Verification
REQ-026 Reset: assert nub_reset mid-OWNER, and rqst_oe, arb_oe and grant_o SHALL be 0 in the same cycle; state SHALL be IDLE after release.
REQ-027 Sole requester: id=4'hA, mst_req=1, bus idle; rqst_oe SHALL rise at T+1, arb_oe=4'hA, grant_o=1 at T+1+ARB_CYCLES+1.
REQ-028 Contention: id=4'h5 vs external arb=4'hC; arb_oe SHALL fall to 4'h4 then 0, no grant; after external rqst drop and redo, grant SHALL follow.
REQ-029 Fairness: rqst=1 from others when mst_req rises; the block SHALL hold in FAIRWAIT, with rqst_oe=0 until rqst=0.
REQ-030 Busy bus: won arbitration while start seen, ack 3 clocks later; grant_o SHALL rise the clock after ack; an attention cycle (start&ack) SHALL not set busy.
REQ-031 Lock: mst_lock=1 over two transactions; rqst_oe SHALL stay 1 and grant_o stay 1 until the ack after mst_lock=0.
